// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver, its interface and the baud divider.
//   uart_state_e : frame state machine encoding
//   OVERSAMPLE   : oversample ticks per bit
//   MID_SAMPLE   : sample index of mid-bit during start-bit qualification
//   DATA_BITS    : payload bits per frame
//   even_parity  : even parity over one data byte
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_SAMPLE = 7;
    localparam int unsigned DATA_BITS  = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte-stream handshake between the UART receiver and its consumer.
// Optional feature macro: UART_RX_PARITY_EN adds rx_parity_err.
//   rx_data       : received byte                     (master -> slave)
//   rx_valid      : rx_data holds an unconsumed byte  (master -> slave)
//   rx_ready      : consumer accepts on valid&&ready  (slave -> master)
//   rx_frame_err  : one-cycle stop-bit error pulse    (master -> slave)
//   rx_overrun    : one-cycle lost-byte pulse         (master -> slave)
//   rx_parity_err : one-cycle parity error pulse      (master -> slave, parity builds only)
interface uart_rx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_frame_err;
    logic                 rx_overrun;
`ifdef UART_RX_PARITY_EN
    logic                 rx_parity_err;
`endif

    modport master (
        output rx_data,
        output rx_valid,
        output rx_frame_err,
        output rx_overrun,
`ifdef UART_RX_PARITY_EN
        output rx_parity_err,
`endif
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  rx_frame_err,
        input  rx_overrun,
`ifdef UART_RX_PARITY_EN
        input  rx_parity_err,
`endif
        output rx_ready
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick divider shared by the UART receive and transmit paths.
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   restart : synchronous restart; clears the counter and suppresses tick this cycle
//   tick    : one-cycle pulse every DIV clocks (counter at DIV-1)
module uart_baud_tick #(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CntW-1:0] cnt_q;

    assign tick = !restart && (cnt_q == CntW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (restart || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 (8E1 with UART_RX_PARITY_EN) frames, LSB first, 16x oversampling.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   rx    : asynchronous serial line, idles high
//   bus   : uart_rx_if.master -- rx_data/rx_valid/rx_ready handshake plus error pulses
// Parameters: CLK_FREQ (Hz), BAUD (bit/s); DIV = CLK_FREQ/(BAUD*16) must be at least 1.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rx,
    uart_rx_if.master bus
);

    localparam int unsigned DIV = CLK_FREQ / (BAUD * OVERSAMPLE);

    if (DIV < 1) begin : gen_div_check
        $error("uart_rx: CLK_FREQ/(BAUD*16) must be at least 1");
    end

    logic                 rx_meta_q;
    logic                 rxs_q;
    uart_state_e          state_q;
    logic [3:0]           sc_q;
    logic [2:0]           bitcnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 frame_err_q;
    logic                 overrun_q;
    logic                 tick;
    logic                 start_edge;
    logic                 byte_ok;
    logic                 bit_end;

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    assign start_edge = (state_q == StIdle) && !rxs_q;
    // Once aligned on mid-bit, the 16th tick of each bit lands on mid-bit again.
    assign bit_end    = tick && (sc_q == 4'(OVERSAMPLE - 1));

    uart_baud_tick #(
        .DIV(DIV)
    ) u_baud_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .restart(start_edge),
        .tick   (tick)
    );

`ifdef UART_RX_PARITY_EN
    logic par_bad_q;
    logic parity_err_q;

    assign byte_ok               = rxs_q && !par_bad_q;
    assign bus.rx_parity_err     = parity_err_q;
`else
    assign byte_ok               = rxs_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            sc_q         <= '0;
            bitcnt_q     <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            // A byte loaded later in this block overrides the consume.
            if (valid_q && bus.rx_ready) begin
                valid_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (!rxs_q) begin
                        sc_q    <= '0;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (tick) begin
                        if (sc_q == 4'(MID_SAMPLE)) begin
                            if (rxs_q) begin
                                state_q <= StIdle;
                            end else begin
                                sc_q     <= '0;
                                bitcnt_q <= '0;
                                state_q  <= StData;
                            end
                        end else begin
                            sc_q <= sc_q + 4'd1;
                        end
                    end
                end
                StData: begin
                    if (tick) begin
                        sc_q <= sc_q + 4'd1;
                    end
                    if (bit_end) begin
                        shift_q[bitcnt_q] <= rxs_q;
                        bitcnt_q          <= bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= StParity;
`else
                            state_q <= StStop;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (tick) begin
                        sc_q <= sc_q + 4'd1;
                    end
                    if (bit_end) begin
                        par_bad_q <= (rxs_q != even_parity(shift_q));
                        state_q   <= StStop;
                    end
                end
`endif
                StStop: begin
                    if (tick) begin
                        sc_q <= sc_q + 4'd1;
                    end
                    if (bit_end) begin
                        state_q     <= StIdle;
                        frame_err_q <= !rxs_q;
`ifdef UART_RX_PARITY_EN
                        parity_err_q <= par_bad_q;
`endif
                        if (byte_ok) begin
                            data_q    <= shift_q;
                            valid_q   <= 1'b1;
                            overrun_q <= valid_q && !bus.rx_ready;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.rx_data      = data_q;
    assign bus.rx_valid     = valid_q;
    assign bus.rx_frame_err = frame_err_q;
    assign bus.rx_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at DIV = 4 (64 clocks per bit).
// A negedge monitor pops expected bytes from a scoreboard queue on every accepted beat and
// counts error pulses; the stimulus side compares those counts per frame.
// Honours UART_RX_PARITY_EN when defined.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int unsigned CLK_FREQ = 614_400;
    localparam int unsigned BAUD     = 9600;
    localparam int          BIT_CLKS = 64;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;

    uart_rx_if bus ();

    uart_rx #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .rx   (rx),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int bad    = 0;
    int beats  = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int pe_cnt = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_beats;
        int         exp_fe;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        step(BIT_CLKS);
    endtask

    // par_flip inverts the (otherwise correct) even parity bit in parity builds.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i]);
        end
        if (PAR_EN) begin
            send_bit((^d) ^ par_flip);
        end
        send_bit(stop);
        rx = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rx_valid && bus.rx_ready) begin
                beats++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got %0h want none", bus.rx_data);
                end else begin
                    chk("beat_data", {24'h0, bus.rx_data}, {24'h0, exp_q.pop_front()});
                end
            end
            if (bus.rx_frame_err) fe_cnt++;
            if (bus.rx_overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
            if (bus.rx_parity_err) pe_cnt++;
`endif
        end
    end

    initial begin
        int b0, f0, o0, p0;

        vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
        vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
        vecs[3] = '{8'h3C, 1'b0, 0, 1, 8'hFF};
        vecs[4] = '{8'h81, 1'b1, 1, 0, 8'h81};
        vecs[5] = '{8'h5A, 1'b1, 1, 0, 8'h5A};

        bus.rx_ready = 1'b1;
        #2;
        chk("reset_data", {24'h0, bus.rx_data}, 32'h0);
        chk("reset_valid", {31'h0, bus.rx_valid}, 32'h0);
        chk("reset_frame_err", {31'h0, bus.rx_frame_err}, 32'h0);
        chk("reset_overrun", {31'h0, bus.rx_overrun}, 32'h0);
        step(3);
        rst_n = 1'b1;
        step(BIT_CLKS);

        foreach (vecs[i]) begin
            b0 = beats;
            f0 = fe_cnt;
            o0 = ov_cnt;
            if (vecs[i].exp_beats != 0) exp_q.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop, 1'b0);
            step(8);
            chk($sformatf("v%0d_beats", i), 32'(beats - b0), 32'(vecs[i].exp_beats));
            chk($sformatf("v%0d_frame_err", i), 32'(fe_cnt - f0), 32'(vecs[i].exp_fe));
            chk($sformatf("v%0d_overrun", i), 32'(ov_cnt - o0), 32'h0);
            chk($sformatf("v%0d_data", i), {24'h0, bus.rx_data}, {24'h0, vecs[i].exp_data});
            chk($sformatf("v%0d_valid", i), {31'h0, bus.rx_valid}, 32'h0);
            step(2 * BIT_CLKS);
        end

        // Short low glitch must be rejected as a false start.
        b0 = beats;
        f0 = fe_cnt;
        rx = 1'b0;
        step(16);
        rx = 1'b1;
        step(2 * BIT_CLKS);
        chk("glitch_beats", 32'(beats - b0), 32'h0);
        chk("glitch_frame_err", 32'(fe_cnt - f0), 32'h0);
        chk("glitch_valid", {31'h0, bus.rx_valid}, 32'h0);
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0);
        step(8);
        chk("post_glitch_beats", 32'(beats - b0), 32'h1);
        step(2 * BIT_CLKS);

        // Back-to-back frames with the consumer stalled: second byte overruns the first.
        bus.rx_ready = 1'b0;
        b0 = beats;
        o0 = ov_cnt;
        f0 = fe_cnt;
        exp_q.push_back(8'h22);
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        step(8);
        chk("ovr_pulses", 32'(ov_cnt - o0), 32'h1);
        chk("ovr_valid", {31'h0, bus.rx_valid}, 32'h1);
        chk("ovr_data", {24'h0, bus.rx_data}, 32'h22);
        chk("ovr_frame_err", 32'(fe_cnt - f0), 32'h0);
        bus.rx_ready = 1'b1;
        step(4);
        chk("ovr_beats", 32'(beats - b0), 32'h1);
        step(2 * BIT_CLKS);

        // Reset during data bit 4 clears a held byte and the partial frame.
        bus.rx_ready = 1'b0;
        send_frame(8'h96, 1'b1, 1'b0);
        step(8);
        chk("pre_rst_valid", {31'h0, bus.rx_valid}, 32'h1);
        chk("pre_rst_data", {24'h0, bus.rx_data}, 32'h96);
        fork
            send_frame(8'hFF, 1'b1, 1'b1);
            begin
                step(5 * BIT_CLKS + BIT_CLKS / 2);
                rst_n = 1'b0;
                #1;
                chk("rst_data", {24'h0, bus.rx_data}, 32'h0);
                chk("rst_valid", {31'h0, bus.rx_valid}, 32'h0);
                chk("rst_frame_err", {31'h0, bus.rx_frame_err}, 32'h0);
                chk("rst_overrun", {31'h0, bus.rx_overrun}, 32'h0);
                step(3);
                rst_n = 1'b1;
            end
        join
        step(2 * BIT_CLKS);
        bus.rx_ready = 1'b1;
        b0 = beats;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0);
        step(8);
        chk("post_rst_beats", 32'(beats - b0), 32'h1);
        step(2 * BIT_CLKS);

        if (PAR_EN) begin
            b0 = beats;
            f0 = fe_cnt;
            p0 = pe_cnt;
            send_frame(8'h07, 1'b1, 1'b1);
            step(8);
            chk("par_bad_pulses", 32'(pe_cnt - p0), 32'h1);
            chk("par_bad_beats", 32'(beats - b0), 32'h0);
            chk("par_bad_frame_err", 32'(fe_cnt - f0), 32'h0);
            step(2 * BIT_CLKS);
            p0 = pe_cnt;
            exp_q.push_back(8'h07);
            send_frame(8'h07, 1'b1, 1'b0);
            step(8);
            chk("par_ok_beats", 32'(beats - b0), 32'h1);
            chk("par_ok_pulses", 32'(pe_cnt - p0), 32'h0);
            step(2 * BIT_CLKS);
        end

        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) begin
            step(1);
        end
        chk("scoreboard_drain", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the serial link. It deserialises 8N1 frames (8 data bits, LSB first, no parity, 1 stop bit) from the asynchronous `rx` line and presents each received byte on a valid/ready interface to the core. It uses 16x oversampling from an internal baud-tick divider. It is the receive-side counterpart of the transmit path's bit-select datapath.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 9600: line rate in bit/s.
- `DIV`, derived as CLK_FREQ/(BAUD*16): clocks per oversample tick. Elaboration fails if DIV < 1.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: reset. Asynchronous assert, active-low.
- `rx` in 1: serial line. Asynchronous; idles high.
- `rx_data` out 8: last received byte.
- `rx_valid` out 1: `rx_data` holds an unconsumed byte.
- `rx_ready` in 1: consumer accepts the byte when `rx_valid` && `rx_ready`.
- `rx_frame_err` out 1: one-cycle pulse when the stop bit is sampled low.
- `rx_overrun` out 1: one-cycle pulse when a byte is lost to an unconsumed predecessor.
- `rx_parity_err` out 1: exists only with `UART_RX_PARITY_EN`. One-cycle pulse on parity mismatch.

## Operation
- Reset values:
  - all outputs are 0 (`rx_data` = 8'h00);
  - the synchroniser flops are 1;
  - state is IDLE;
  - the tick and bit counters are 0.
- `rx` passes through a 2-FF synchroniser. All logic uses the synchronised value `rxs`.
- Tick generator: counter 0..DIV-1, producing a one-cycle `tick` at DIV-1. It is forced to 0 on start-edge detection.
- Sample counter `sc` runs 0..15 on ticks. The bit is sampled at `sc` == 7 (mid-bit).
- State machine (LSB first):
  - IDLE: when `rxs` is 0 (falling edge), clear `sc` and go to START.
  - START: at `sc` == 7:
    - if `rxs` is 1, it is a false start: go back to IDLE with no output;
    - otherwise clear `sc` (re-aligning to mid-bit) and go to DATA.
  - DATA: at every 16th tick, shift `rxs` into bit[`bitcnt`]. After bit 7, go to STOP (or to PARITY when enabled).
  - PARITY: 16 ticks later, sample the parity bit, then go to STOP.
  - STOP: 16 ticks later, sample the stop bit, then go to IDLE in the same cycle. IDLE can detect the next start edge from the following cycle, so back-to-back frames are supported.
- Stop sample = 1 (and parity ok):
  - load `rx_data` and set `rx_valid`;
  - if `rx_valid` was already 1 and `rx_ready` is 0 in that cycle, pulse `rx_overrun`. The new byte overwrites the old one.
- Stop sample = 0: pulse `rx_frame_err`. `rx_data` and `rx_valid` are unchanged and the byte is discarded.
- `rx_valid` clears the cycle after `rx_valid` && `rx_ready`.
- Accept and new byte in the same cycle: no overrun. The new byte is loaded and `rx_valid` stays 1.
- Reset mid-frame: everything returns immediately to reset values and any partial byte is lost.

## Timing
- Line to `rxs`: 2 clocks.
- Start-edge decision: 8 ticks (about half a bit) after the edge.
- `rx_valid`, `rx_frame_err` and `rx_overrun` assert 1 clock after the stop-bit sample tick (registered outputs).
- End to end: the byte is available about 9.5 bit times after the start edge (10.5 with parity), plus 3 clocks.
- Sampling point error is at most 1 tick (1/16 bit) plus 2 clocks.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - the frame is 8E1; even parity is computed over the 8 data bits;
  - the PARITY state and the `rx_parity_err` port exist;
  - on mismatch, `rx_parity_err` pulses at the stop-sample cycle + 1 and the byte is discarded (not delivered);
  - if the stop bit is also 0, both error pulses fire together.
- Undefined: 8N1; no PARITY state, no `rx_parity_err` port.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - `OVERSAMPLE` = 16;
  - `MID_SAMPLE` = 7;
  - `DATA_BITS` = 8.
- One sub-module: `uart_baud_tick` (divider producing `tick`, with synchronous `restart` input). The transmitter reuses it.

## Test plan
- Send 8'hA5 (8N1) at DIV = 4 with `rx_ready` = 1 → one `rx_valid` beat with `rx_data` = 8'hA5, no error pulses.
- Low glitch of 4 ticks on an idle line → FSM returns to IDLE; no `rx_valid` and no `rx_frame_err`.
- Frame 8'h3C with stop bit = 0 → `rx_frame_err` pulses once; `rx_valid` stays 0; `rx_data` is unchanged.
- Back-to-back 8'h11 then 8'h22 with `rx_ready` = 0 → `rx_overrun` pulses once at the second byte; `rx_data` = 8'h22 and `rx_valid` = 1.
- Assert `rst_n` = 0 during data bit 4 of 8'hFF, release, then send 8'h5A → only 8'h5A is delivered; all outputs are 0 during reset.
- With `UART_RX_PARITY_EN`: 8'h07 sent with parity bit = 0 (wrong) → `rx_parity_err` pulses once and there is no `rx_valid`. Sent with parity bit = 1 → 8'h07 is delivered.
